// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses a combinational instruction ROM and buffers
// fetched {pc, word} pairs in a small FIFO for decode (valid/ready handshake).
// A branch redirect flushes the buffer and reloads the PC.
//
// Optional feature macro: HALT_ON_ZERO_EN
//   defined   - a zero word (unmapped ROM) is not buffered; fetch enters HALTED until a redirect
//               or reset. The buffer still drains.
//   undefined - zero words are ordinary instructions; halted_o is tied low.
//
// Ports:
//   clk_i             rising-edge clock
//   rst_ni            synchronous reset, active-low
//   imem_address_o    ROM address (current PC)
//   imem_data_i       ROM word for imem_address_o, valid the same cycle
//   instr_o           FIFO head instruction (0 when empty)
//   instr_pc_o        address of instr_o (0 when empty)
//   instr_valid_o     FIFO non-empty
//   instr_ready_i     decode accepts head when instr_valid_o & instr_ready_i
//   branch_valid_i    redirect request
//   branch_target_i   redirect address, bits [1:0] cleared on load
//   stall_i           freeze all state; redirect is ignored while set
//   halted_o          fetch stopped
//   fetch_count_o     instructions pushed since reset, saturating
module instruction_fetch_unit #(
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        DATA_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter logic [ADDR_W-1:0]  PC_STEP    = ADDR_W'(4),
  parameter int unsigned        FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [ADDR_W-1:0] imem_address_o,
  input  logic [DATA_W-1:0] imem_data_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  input  logic              branch_valid_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              stall_i,
  output logic              halted_o,
  output logic [15:0]       fetch_count_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;
  typedef enum logic [0:0] {StFetch, StHalted} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  ptr_t                rd_ptr_q, rd_ptr_d;
  ptr_t                wr_ptr_q, wr_ptr_d;
  cnt_t                count_q, count_d;
  logic [15:0]         fetch_count_q, fetch_count_d;
  logic [ADDR_W-1:0]   pc_mem_q   [FIFO_DEPTH];
  logic [DATA_W-1:0]   data_mem_q [FIFO_DEPTH];

  logic pop, push, can_push, redirect, full;

  assign instr_valid_o  = (count_q != '0);
  // Depth is a power of two, so the count MSB alone marks "full".
  assign full           = count_q[PtrW];
  assign pop            = instr_valid_o & instr_ready_i & ~stall_i;
  assign redirect       = branch_valid_i & ~stall_i;
  // A full buffer may still accept when the head leaves in the same cycle.
  assign can_push       = (state_q == StFetch) & ~stall_i & ~branch_valid_i & (~full | pop);

`ifdef HALT_ON_ZERO_EN
  logic zero_hit;
  assign zero_hit = can_push & (imem_data_i == '0);
  assign push     = can_push & ~zero_hit;
  assign halted_o = (state_q == StHalted);
`else
  assign push     = can_push;
  assign halted_o = 1'b0;
`endif

  assign imem_address_o = pc_q;
  assign instr_o        = instr_valid_o ? data_mem_q[rd_ptr_q] : '0;
  assign instr_pc_o     = instr_valid_o ? pc_mem_q[rd_ptr_q]   : '0;
  assign fetch_count_o  = fetch_count_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    fetch_count_d = fetch_count_q;
    if (redirect) begin
      // Any same-cycle pop is absorbed by the flush.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = branch_target_i & ~ADDR_W'(3);
      state_d  = StFetch;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      if (push) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
        pc_d     = pc_q + PC_STEP;
        if (fetch_count_q != 16'hFFFF) fetch_count_d = fetch_count_q + 16'd1;
      end
      if (push && !pop)      count_d = count_q + cnt_t'(1);
      else if (pop && !push) count_d = count_q - cnt_t'(1);
`ifdef HALT_ON_ZERO_EN
      if (zero_hit) state_d = StHalted;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= pc_q;
      data_mem_q[wr_ptr_q] <= imem_data_i;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0)
  logic        rst_n, ready, stall, br;
  logic [31:0] tgt, addr, data, instr, instr_pc;
  logic        valid, halted;
  logic [15:0] fc;

  // Second DUT for PC wrap (RESET_PC = FFFFFFF8)
  logic        rst_w, ready_w;
  logic [31:0] addr_w, data_w, instr_w, pc_w;
  logic        valid_w, halted_w;
  logic [15:0] fc_w;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h40) ? 32'h0 : {16'hE3A0, a[15:0]};
  endfunction

  assign data   = rom(addr);
  assign data_w = rom(addr_w);

  instruction_fetch_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .imem_address_o(addr), .imem_data_i(data),
    .instr_o(instr), .instr_pc_o(instr_pc), .instr_valid_o(valid), .instr_ready_i(ready),
    .branch_valid_i(br), .branch_target_i(tgt), .stall_i(stall), .halted_o(halted),
    .fetch_count_o(fc)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk_i(clk), .rst_ni(rst_w), .imem_address_o(addr_w), .imem_data_i(data_w),
    .instr_o(instr_w), .instr_pc_o(pc_w), .instr_valid_o(valid_w), .instr_ready_i(ready_w),
    .branch_valid_i(1'b0), .branch_target_i(32'h0), .stall_i(1'b0), .halted_o(halted_w),
    .fetch_count_o(fc_w)
  );

  typedef struct {
    logic        rst_n, ready, stall, br;
    logic [31:0] tgt;
    logic        v;
    logic [31:0] pc, addr;
    logic [15:0] fc;
  } vec_t;

  vec_t        tbl [28];
  int          n_checks = 0;
  int          n_err = 0;
  int          n_acc = 0;
  bit          sb_en = 1'b0;
  logic [31:0] q [$];
  logic [31:0] q_w [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic rd, input logic s, input logic b,
                              input logic [31:0] t, input logic v, input logic [31:0] p,
                              input logic [31:0] a, input logic [15:0] f);
    vec_t x;
    x.rst_n = r; x.ready = rd; x.stall = s; x.br = b; x.tgt = t;
    x.v = v; x.pc = p; x.addr = a; x.fc = f;
    return x;
  endfunction

  // One cycle from a negedge: score accepted heads, then advance past the next posedge.
  task automatic cyc();
    logic [31:0] e;
    #1;
    if (sb_en && valid && ready && !stall) begin
      if (q.size() == 0) chk("sb_unexpected", instr_pc, 32'hDEAD_BEEF);
      else begin
        e = q.pop_front();
        chk("sb_pc", instr_pc, e);
        chk("sb_instr", instr, rom(e));
        n_acc++;
      end
    end
    if (valid_w && ready_w) begin
      if (q_w.size() == 0) chk("w_unexpected", pc_w, 32'hDEAD_BEEF);
      else begin
        e = q_w.pop_front();
        chk("w_pc", pc_w, e);
        chk("w_instr", instr_w, rom(e));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    // rows: rst_n ready stall br tgt | valid instr_pc addr fetch_count (state seen before edge)
    tbl[0]  = mk(1, 1, 0, 0, 0,      0, 32'h00,  32'h00,  0);
    tbl[1]  = mk(1, 1, 0, 0, 0,      1, 32'h00,  32'h04,  1);
    tbl[2]  = mk(1, 1, 0, 0, 0,      1, 32'h04,  32'h08,  2);
    tbl[3]  = mk(1, 1, 0, 0, 0,      1, 32'h08,  32'h0C,  3);
    tbl[4]  = mk(1, 1, 0, 0, 0,      1, 32'h0C,  32'h10,  4);
    tbl[5]  = mk(0, 1, 0, 0, 0,      1, 32'h10,  32'h14,  5);
    tbl[6]  = mk(0, 0, 0, 0, 0,      0, 32'h00,  32'h00,  0);
    tbl[7]  = mk(1, 0, 0, 0, 0,      0, 32'h00,  32'h00,  0);
    tbl[8]  = mk(1, 0, 0, 0, 0,      1, 32'h00,  32'h04,  1);
    tbl[9]  = mk(1, 0, 0, 0, 0,      1, 32'h00,  32'h08,  2);
    tbl[10] = mk(1, 0, 0, 0, 0,      1, 32'h00,  32'h08,  2);
    tbl[11] = mk(1, 0, 0, 0, 0,      1, 32'h00,  32'h08,  2);
    tbl[12] = mk(1, 0, 0, 0, 0,      1, 32'h00,  32'h08,  2);
    tbl[13] = mk(1, 1, 0, 0, 0,      1, 32'h00,  32'h08,  2);
    tbl[14] = mk(1, 1, 0, 0, 0,      1, 32'h04,  32'h0C,  3);
    tbl[15] = mk(1, 1, 0, 0, 0,      1, 32'h08,  32'h10,  4);
    tbl[16] = mk(1, 1, 0, 1, 32'h2E, 1, 32'h0C,  32'h14,  5);
    tbl[17] = mk(1, 1, 0, 0, 0,      0, 32'h00,  32'h2C,  5);
    tbl[18] = mk(1, 1, 0, 0, 0,      1, 32'h2C,  32'h30,  6);
    tbl[19] = mk(1, 1, 1, 1, 32'h100, 1, 32'h30, 32'h34,  7);
    tbl[20] = mk(1, 1, 1, 1, 32'h100, 1, 32'h30, 32'h34,  7);
    tbl[21] = mk(1, 1, 1, 1, 32'h100, 1, 32'h30, 32'h34,  7);
    tbl[22] = mk(1, 1, 0, 1, 32'h100, 1, 32'h30, 32'h34,  7);
    tbl[23] = mk(1, 1, 0, 0, 0,      0, 32'h00,  32'h100, 7);
    tbl[24] = mk(1, 1, 0, 0, 0,      1, 32'h100, 32'h104, 8);
    tbl[25] = mk(1, 1, 0, 1, 32'h40, 1, 32'h104, 32'h108, 9);
    tbl[26] = mk(1, 1, 0, 0, 0,      0, 32'h00,  32'h40,  9);
    tbl[27] = mk(1, 1, 0, 0, 0,      1, 32'h40,  32'h44,  10);

    rst_n = 0; ready = 0; stall = 0; br = 0; tgt = 0;
    rst_w = 0; ready_w = 0;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 28; i++) begin
      rst_n = tbl[i].rst_n; ready = tbl[i].ready; stall = tbl[i].stall;
      br = tbl[i].br; tgt = tbl[i].tgt;
      #1;
      chk($sformatf("row%0d_valid", i), {31'b0, valid}, {31'b0, tbl[i].v});
      chk($sformatf("row%0d_pc", i), instr_pc, tbl[i].pc);
      chk($sformatf("row%0d_instr", i), instr, tbl[i].v ? rom(tbl[i].pc) : 32'h0);
      chk($sformatf("row%0d_addr", i), addr, tbl[i].addr);
      chk($sformatf("row%0d_fcount", i), {16'b0, fc}, {16'b0, tbl[i].fc});
      chk($sformatf("row%0d_halted", i), {31'b0, halted}, 32'h0);
      @(negedge clk);
    end

    // Random ready from a fresh reset: accepted heads must follow the sequential PC stream.
    rst_n = 0; ready = 0; br = 0; stall = 0;
    cyc();
    rst_n = 1;
    for (int k = 0; k < 48; k++) q.push_back(32'(k * 4));
    sb_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ready = 1'($urandom_range(0, 1));
      cyc();
    end
    sb_en = 1'b0;
    ready = 0;
    chk("sb_accept_count_ok", {31'b0, (n_acc >= 8)}, 32'h1);

    // PC wrap on the second instance, then reset mid-run empties it.
    rst_w = 1; ready_w = 1;
    q_w.push_back(32'hFFFF_FFF8);
    q_w.push_back(32'hFFFF_FFFC);
    q_w.push_back(32'h0000_0000);
    q_w.push_back(32'h0000_0004);
    for (int k = 0; k < 5; k++) cyc();
    chk("w_queue_drained", 32'(q_w.size()), 32'h0);
    ready_w = 0; rst_w = 0;
    cyc();
    #1;
    chk("w_reset_valid", {31'b0, valid_w}, 32'h0);
    chk("w_reset_addr", addr_w, 32'hFFFF_FFF8);
    chk("w_reset_fcount", {16'b0, fc_w}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
